// File: rtl/tff_count_sequencer.sv
// Bounded up/down counter built from a bank of WIDTH toggle flip-flops; every
// state change is a toggle vector. Define TFF_AUTO_RELOAD_EN to wrap at terminal count.
module tff_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             up_down,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] t_vec_c;
  logic [WIDTH-1:0] up_t, dn_t;

  // Ripple toggle rules: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q_q[i-1];
      dn_t[i] = dn_t[i-1] & ~q_q[i-1];
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    t_vec_c = '0;
    if (state_q == IDLE) begin
      if (start && !stop) begin
        limit_d = limit;
        dir_d   = up_down;
        // Load is a toggle too: flip exactly the bits that differ from the target.
        t_vec_c = up_down ? q_q : (q_q ^ limit);
        state_d = RUN;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else if (dir_q) begin
      if (q_q == limit_q) begin
        t_vec_c = q_q;
        done_d  = 1'b1;
`ifndef TFF_AUTO_RELOAD_EN
        state_d = IDLE;
`endif
      end else begin
        t_vec_c = up_t;
      end
    end else begin
      if (q_q == '0) begin
        done_d  = 1'b1;
`ifdef TFF_AUTO_RELOAD_EN
        t_vec_c = limit_q;
`else
        state_d = IDLE;
`endif
      end else begin
        t_vec_c = dn_t;
      end
    end
    q_d    = q_q ^ t_vec_c;
    busy_d = (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      limit_q <= '0;
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign t_vec = rst_n ? t_vec_c : '0;
  assign q     = q_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed bench for tff_count_sequencer: reset, up/down runs, abort, edges,
// back-to-back starts and (when TFF_AUTO_RELOAD_EN is defined) the reload wrap.
module tb_tff_count_sequencer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             up_down;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  int vectors;
  int miscompares;

  tff_count_sequencer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .up_down (up_down),
    .limit   (limit),
    .t_vec   (t_vec),
    .q       (q),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [WIDTH-1:0] exp_q,
                           input logic exp_busy, input logic exp_done);
    vectors++;
    if (q !== exp_q || busy !== exp_busy || done !== exp_done) begin
      miscompares++;
      $display("FAIL %s: q=%0d busy=%b done=%b, expected q=%0d busy=%b done=%b",
               name, q, busy, done, exp_q, exp_busy, exp_done);
    end
  endtask

  task automatic check_tvec(input string name, input logic [WIDTH-1:0] exp_t);
    vectors++;
    if (t_vec !== exp_t) begin
      miscompares++;
      $display("FAIL %s: t_vec=%b expected %b", name, t_vec, exp_t);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; up_down = 1'b1; limit = '0;
    #2;
    check_out("reset_init", 4'd0, 1'b0, 1'b0);
    check_tvec("reset_init_tvec", 4'd0);
    tick();
    rst_n = 1'b1;
    // Up run to q = 3, then asynchronous reset between edges.
    limit = 4'd9; up_down = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check_out("reset_prerun_q3", 4'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_out("reset_midrun", 4'd0, 1'b0, 1'b0);
    check_tvec("reset_midrun_tvec", 4'd0);
    rst_n = 1'b1;
    tick();
    check_out("reset_after_edge", 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_up_run();
    limit = 4'd5; up_down = 1'b1; start = 1'b1;
    #1;
    check_tvec("up_load_tvec", 4'd0);
    tick();
    check_out("up_q0", 4'd0, 1'b1, 1'b0);
    // start, limit and direction changes during RUN must be ignored.
    limit = 4'd2; up_down = 1'b0;
    tick();
    start = 1'b0;
    check_out("up_q1", 4'd1, 1'b1, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check_out("up_qi", 4'(i), 1'b1, 1'b0);
    end
    check_tvec("up_terminal_tvec", 4'd5);
    tick();
    check_out("up_done", 4'd0, 1'b0, 1'b1);
    tick();
    check_out("up_after_done", 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_down_run();
    limit = 4'd3; up_down = 1'b0; start = 1'b1;
    #1;
    check_tvec("down_load_tvec", 4'b0011);
    tick();
    start = 1'b0; up_down = 1'b1;
    check_out("down_q3", 4'd3, 1'b1, 1'b0);
    tick();
    check_out("down_q2", 4'd2, 1'b1, 1'b0);
    check_tvec("down_q2_tvec", 4'b0011);
    tick();
    check_out("down_q1", 4'd1, 1'b1, 1'b0);
    tick();
    check_out("down_q0", 4'd0, 1'b1, 1'b0);
    check_tvec("down_terminal_tvec", 4'd0);
    tick();
    check_out("down_done", 4'd0, 1'b0, 1'b1);
    tick();
    check_out("down_hold", 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    limit = 4'd9; up_down = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check_out("abort_q4", 4'd4, 1'b1, 1'b0);
    stop = 1'b1;
    #1;
    check_tvec("abort_stop_tvec", 4'd0);
    tick();
    stop = 1'b0;
    check_out("abort_frozen", 4'd4, 1'b0, 1'b0);
    tick();
    check_out("abort_idle_hold", 4'd4, 1'b0, 1'b0);
    limit = 4'd1; up_down = 1'b1; start = 1'b1;
    #1;
    check_tvec("abort_reload_tvec", 4'b0100);
    tick();
    start = 1'b0;
    check_out("abort_restart_q0", 4'd0, 1'b1, 1'b0);
    tick();
    check_out("abort_restart_q1", 4'd1, 1'b1, 1'b0);
    tick();
    check_out("abort_restart_done", 4'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_edges();
    // limit = all ones
    limit = 4'd15; up_down = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check_out("edge_max_qi", 4'(i), 1'b1, 1'b0);
    end
    tick();
    check_out("edge_max_done", 4'd0, 1'b0, 1'b1);
    tick();
    check_out("edge_max_after", 4'd0, 1'b0, 1'b0);
    // limit = 0 up: first RUN cycle is terminal
    limit = 4'd0; up_down = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check_out("edge_zero_run", 4'd0, 1'b1, 1'b0);
    tick();
    check_out("edge_zero_done", 4'd0, 1'b0, 1'b1);
    tick();
    // start and stop together in IDLE: no run
    limit = 4'd5; up_down = 1'b0; start = 1'b1; stop = 1'b1;
    #1;
    check_tvec("edge_startstop_tvec", 4'd0);
    tick();
    check_out("edge_startstop", 4'd0, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    limit = 4'd1; up_down = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_out("b2b_q1", 4'd1, 1'b1, 1'b0);
    tick();
    check_out("b2b_done", 4'd0, 1'b0, 1'b1);
    limit = 4'd2; up_down = 1'b0; start = 1'b1;
    #1;
    check_tvec("b2b_load_tvec", 4'b0010);
    tick();
    start = 1'b0;
    check_out("b2b_second_q2", 4'd2, 1'b1, 1'b0);
    tick(); tick();
    check_out("b2b_second_q0", 4'd0, 1'b1, 1'b0);
    tick();
    check_out("b2b_second_done", 4'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_auto_reload();
    limit = 4'd2; up_down = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check_out("ar_q2", 4'd2, 1'b1, 1'b0);
    for (int w = 0; w < 3; w++) begin
      tick();
      check_out("ar_q1", 4'd1, 1'b1, 1'b0);
      tick();
      check_out("ar_q0", 4'd0, 1'b1, 1'b0);
      check_tvec("ar_reload_tvec", 4'd2);
      tick();
      check_out("ar_wrap", 4'd2, 1'b1, 1'b1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_out("ar_stop", 4'd2, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
`ifdef TFF_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_up_run();
    test_down_run();
    test_abort();
    test_edges();
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
